// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle control FSM for the core.
// Fetches an instruction over a request/ready handshake, holds it for the
// decoder, then steps the datapath through EXECUTE, MEMORY and WRITEBACK.
// Owns the PC, the register-file write strobe and the retired counter.
//
// Build option: define SEQUENCER_HALT_ON_INVALID_EN to stop the core in HALT
// on an invalid instruction. Left undefined, an invalid instruction is
// skipped (PC+4, no write strobe, not counted as retired).
module instruction_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] InstrAddress,
    output logic        InstrRequest,
    input  logic        InstrReady,
    input  logic [31:0] InstrData,
    output logic [31:0] Instruction,
    input  logic        WritesRegisterFile,
    input  logic        WritesRam,
    input  logic        ReadsRam,
    input  logic        InvalidInstructionSignal,
    input  logic        PCLoad,
    input  logic [31:0] PCTarget,
    output logic        DataRequest,
    output logic        DataWrite,
    input  logic        DataReady,
    output logic        RegWriteEnable,
    output logic        Halted,
    output logic [31:0] RetiredCount,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
    logic        lat_write_rf;
    logic        lat_write_ram;
    logic        lat_read_ram;
    logic        lat_invalid;
    logic        redirect;
    logic [31:0] target;

    // State register; reset wins in every state, including mid-handshake.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (Reset) state <= FETCH;
        else       state <= next_state;
    end

    // Next-state logic: handshakes advance only in their own state.
    always_comb begin
        // NOTE: default first so no path through the case leaves next_state
        // unassigned, which would infer a latch.
        next_state = state;
        case (state)
            FETCH:     if (InstrReady) next_state = DECODE;
            DECODE: begin
                if (InvalidInstructionSignal) begin
`ifdef SEQUENCER_HALT_ON_INVALID_EN
                    next_state = HALT;
`else
                    next_state = WRITEBACK;
`endif
                end else begin
                    next_state = EXECUTE;
                end
            end
            EXECUTE:   next_state = (lat_read_ram || lat_write_ram) ? MEMORY : WRITEBACK;
            MEMORY:    if (DataReady) next_state = WRITEBACK;
            WRITEBACK: next_state = FETCH;
            HALT:      next_state = HALT;
            default:   next_state = FETCH;
        endcase
    end

    // Datapath registers: instruction, decoder flags, redirect, PC, counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc            <= RESET_PC;
            instr         <= 32'd0;
            retired       <= 32'd0;
            lat_write_rf  <= 1'b0;
            lat_write_ram <= 1'b0;
            lat_read_ram  <= 1'b0;
            lat_invalid   <= 1'b0;
            redirect      <= 1'b0;
            target        <= 32'd0;
        end else begin
            case (state)
                FETCH: if (InstrReady) instr <= InstrData;
                DECODE: begin
                    lat_write_rf  <= WritesRegisterFile;
                    lat_write_ram <= WritesRam;
                    lat_read_ram  <= ReadsRam;
                    lat_invalid   <= InvalidInstructionSignal;
                    // A skipped invalid instruction never visits EXECUTE, so
                    // drop any redirect left over from the previous one.
                    redirect      <= 1'b0;
                end
                EXECUTE: begin
                    redirect <= PCLoad;
                    target   <= PCTarget & ~32'h0000_0003;
                end
                WRITEBACK: begin
                    pc <= redirect ? target : pc + 32'd4;
                    if (!lat_invalid) retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; requests and strobes are masked in reset.
    always_comb begin
        InstrRequest   = 1'b0;
        DataRequest    = 1'b0;
        DataWrite      = 1'b0;
        RegWriteEnable = 1'b0;
        if (!Reset) begin
            InstrRequest   = (state == FETCH);
            DataRequest    = (state == MEMORY);
            DataWrite      = (state == MEMORY) && lat_write_ram;
            RegWriteEnable = (state == WRITEBACK) && lat_write_rf
                             && !lat_write_ram && !lat_invalid;
        end
`ifdef SEQUENCER_HALT_ON_INVALID_EN
        Halted = (state == HALT);
`else
        Halted = 1'b0;
`endif
    end

    assign InstrAddress = pc;
    assign Instruction  = instr;
    assign RetiredCount = retired;
    assign State        = state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed bench for instruction_sequencer.
// Each instruction is expanded by a transaction-level model into the cycle
// by cycle outputs it must produce; a negedge compare process checks them.
module tb_instruction_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] ADD = 32'h0020_81B3;
    localparam logic [31:0] LW  = 32'h0000_2183;
    localparam logic [31:0] SW  = 32'h0030_A023;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] InstrAddress;
    logic        InstrRequest;
    logic        InstrReady;
    logic [31:0] InstrData;
    logic [31:0] Instruction;
    logic        WritesRegisterFile;
    logic        WritesRam;
    logic        ReadsRam;
    logic        InvalidInstructionSignal;
    logic        PCLoad;
    logic [31:0] PCTarget;
    logic        DataRequest;
    logic        DataWrite;
    logic        DataReady;
    logic        RegWriteEnable;
    logic        Halted;
    logic [31:0] RetiredCount;
    logic [2:0]  State;

    always #5 Clock = ~Clock;

    instruction_sequencer #(.RESET_PC(RPC)) dut (
        .Clock(Clock), .Reset(Reset),
        .InstrAddress(InstrAddress), .InstrRequest(InstrRequest),
        .InstrReady(InstrReady), .InstrData(InstrData),
        .Instruction(Instruction),
        .WritesRegisterFile(WritesRegisterFile), .WritesRam(WritesRam),
        .ReadsRam(ReadsRam), .InvalidInstructionSignal(InvalidInstructionSignal),
        .PCLoad(PCLoad), .PCTarget(PCTarget),
        .DataRequest(DataRequest), .DataWrite(DataWrite), .DataReady(DataReady),
        .RegWriteEnable(RegWriteEnable), .Halted(Halted),
        .RetiredCount(RetiredCount), .State(State)
    );

    typedef struct {
        logic [2:0]  st;
        logic        ireq;
        logic        dreq;
        logic        dwr;
        logic        rwe;
        logic        halted;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Architectural model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ret;
    logic        m_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_cycle(input logic [2:0] st, input logic ireq, input logic dreq,
                                input logic dwr, input logic rwe);
        exp_t e;
        e.st = st; e.ireq = ireq; e.dreq = dreq; e.dwr = dwr; e.rwe = rwe;
        e.halted = m_halted; e.addr = m_pc; e.instr = m_instr; e.ret = m_ret;
        exp_q.push_back(e);
    endtask

    // Inputs outside their own state get random values; the DUT must ignore them.
    task automatic noise();
        InstrReady               = 1'($urandom_range(0, 1));
        InstrData                = $urandom;
        WritesRegisterFile       = 1'($urandom_range(0, 1));
        WritesRam                = 1'($urandom_range(0, 1));
        ReadsRam                 = 1'($urandom_range(0, 1));
        InvalidInstructionSignal = 1'($urandom_range(0, 1));
        PCLoad                   = 1'($urandom_range(0, 1));
        PCTarget                 = $urandom;
        DataReady                = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        noise();
    endtask

    // Compare process: one expected record per clock, sampled mid-cycle.
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state",          32'(State),          32'(e.st));
            check("instr_request",  32'(InstrRequest),   32'(e.ireq));
            check("data_request",   32'(DataRequest),    32'(e.dreq));
            if (e.dreq) check("data_write", 32'(DataWrite), 32'(e.dwr));
            check("reg_write",      32'(RegWriteEnable), 32'(e.rwe));
            check("halted",         32'(Halted),         32'(e.halted));
            check("instr_address",  InstrAddress,        e.addr);
            check("instruction",    Instruction,         e.instr);
            check("retired_count",  RetiredCount,        e.ret);
        end
    end

    // One reset cycle starting from state cur; the model returns to its reset values.
    task automatic do_reset(input logic [2:0] cur);
        Reset = 1'b1;
        expect_cycle(cur, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        Reset    = 1'b0;
        m_pc     = RPC;
        m_instr  = 32'd0;
        m_ret    = 32'd0;
        m_halted = 1'b0;
    endtask

    // Run one instruction end to end. abort asserts Reset on the second MEMORY cycle.
    task automatic run_instr(input logic [31:0] word, input int fetch_wait,
                             input logic wrf, input logic wram, input logic rram,
                             input logic inv, input int mem_wait,
                             input logic pcl, input logic [31:0] tgt, input logic abort);
        for (int i = 0; i <= fetch_wait; i++) begin
            InstrReady = (i == fetch_wait);
            if (i == fetch_wait) InstrData = word;
            expect_cycle(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        m_instr = word;
        WritesRegisterFile       = wrf;
        WritesRam                = wram;
        ReadsRam                 = rram;
        InvalidInstructionSignal = inv;
        expect_cycle(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        if (inv) begin
`ifdef SEQUENCER_HALT_ON_INVALID_EN
            m_halted = 1'b1;
            for (int i = 0; i < 4; i++) begin
                expect_cycle(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
                tick();
            end
`else
            expect_cycle(3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            m_pc = m_pc + 32'd4;
`endif
            return;
        end
        PCLoad   = pcl;
        PCTarget = tgt;
        expect_cycle(3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        if (rram || wram) begin
            for (int i = 0; i <= mem_wait; i++) begin
                if (abort && i == 1) begin
                    do_reset(3'd3);
                    return;
                end
                DataReady = (i == mem_wait);
                expect_cycle(3'd3, 1'b0, 1'b1, wram, 1'b0);
                tick();
            end
        end
        expect_cycle(3'd4, 1'b0, 1'b0, 1'b0, wrf && !wram);
        tick();
        m_pc  = pcl ? (tgt & ~32'h0000_0003) : m_pc + 32'd4;
        m_ret = m_ret + 32'd1;
    endtask

    initial begin
        Reset    = 1'b1;
        noise();
        m_pc     = RPC;
        m_instr  = 32'd0;
        m_ret    = 32'd0;
        m_halted = 1'b0;
        @(posedge Clock);
        #1;
        noise();
        do_reset(3'd0);
        check("reset_pc",      InstrAddress, 32'h0000_0100);
        check("reset_retired", RetiredCount, 32'd0);

        // Back-to-back ALU ops with ready immediately available.
        repeat (3) run_instr(ADD, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
        check("alu_retired", RetiredCount, 32'd3);
        check("alu_pc",      InstrAddress, 32'h0000_010C);

        // Fetch stalled three cycles.
        run_instr(ADD, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
        check("stall_pc", InstrAddress, 32'h0000_0110);

        // Load with two wait cycles, store, and load+store (store wins).
        run_instr(LW, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 32'd0, 1'b0);
        run_instr(SW, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 32'd0, 1'b0);
        run_instr(SW, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'd0, 1'b0);
        check("mem_retired", RetiredCount, 32'd7);
        check("mem_pc",      InstrAddress, 32'h0000_011C);

        // Invalid instruction.
        run_instr(32'hFFFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'd0, 1'b0);
`ifdef SEQUENCER_HALT_ON_INVALID_EN
        check("halt_flag",    32'(Halted),       32'd1);
        check("halt_pc",      InstrAddress,      32'h0000_011C);
        check("halt_retired", RetiredCount,      32'd7);
        check("halt_no_req",  32'(InstrRequest), 32'd0);
        do_reset(3'd5);
`else
        check("skip_pc",      InstrAddress,      32'h0000_0120);
        check("skip_retired", RetiredCount,      32'd7);
        check("skip_halted",  32'(Halted),       32'd0);
        do_reset(3'd0);
`endif

        // Redirect with low bits masked, then PC wrap past the top of memory.
        run_instr(ADD, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0203, 1'b0);
        check("redirect_pc", InstrAddress, 32'h0000_0200);
        run_instr(ADD, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check("top_pc", InstrAddress, 32'hFFFF_FFFC);
        run_instr(ADD, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
        check("wrap_pc",      InstrAddress, 32'h0000_0000);
        check("wrap_retired", RetiredCount, 32'd3);

        // Reset in the middle of a RAM access.
        run_instr(LW, 0, 1'b1, 1'b0, 1'b1, 1'b0, 5, 1'b0, 32'd0, 1'b1);
        check("abort_state",   32'(State),       32'd0);
        check("abort_pc",      InstrAddress,     32'h0000_0100);
        check("abort_dreq",    32'(DataRequest), 32'd0);
        check("abort_retired", RetiredCount,     32'd0);

        run_instr(ADD, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0);
        check("final_retired", RetiredCount, 32'd1);
        check("final_pc",      InstrAddress, 32'h0000_0104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
